// File: rtl/phy_tx_sched.sv
// Transmit PHY lane scheduler: COM-based link bring-up, then round-robin
// one-byte-per-cycle grant across four FWFT lane FIFOs, IDL when starved.
module phy_tx_sched #(
   parameter logic [7:0]  COM       = 8'hBC,
   parameter logic [7:0]  IDL       = 8'h7C,
   parameter int unsigned INIT_COMS = 4
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [3:0] fifo_empty,
   input  logic [7:0] fifo_data0,
   input  logic [7:0] fifo_data1,
   input  logic [7:0] fifo_data2,
   input  logic [7:0] fifo_data3,
   input  logic       link_active,
   output logic [3:0] pop,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic [1:0] lane_out,
   output logic [1:0] state
);

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned LANES    = 4;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(INIT_COMS);
   localparam logic [CNT_W-1:0] CNT_EXIT = CNT_W'(INIT_COMS - 1);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   state_t           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       rr_q, rr_d;
   logic [7:0]       data_d;
   logic             valid_d;
   logic [1:0]       lane_d;
   logic [1:0]       grant;
   logic             any_ready;
   logic [1:0]       idx;
   logic [7:0]       lane_data [LANES];

   assign lane_data[0] = fifo_data0;
   assign lane_data[1] = fifo_data1;
   assign lane_data[2] = fifo_data2;
   assign lane_data[3] = fifo_data3;
   assign state        = st_q;

   // First non-empty lane at or after rr, wrapping; scanned high-to-low so the nearest wins
   always_comb begin
      grant     = rr_q;
      any_ready = 1'b0;
      idx       = rr_q;
      for (int k = LANES - 1; k >= 0; k--) begin
         idx = rr_q + 2'(k);
         if (!fifo_empty[idx]) begin
            grant     = idx;
            any_ready = 1'b1;
         end
      end
   end

   // Dequeue strobe; gated by reset so the comb path is dead while held in reset
   always_comb begin
      pop = '0;
      if (reset && (st_q == ST_ACTIVE) && link_active && any_ready) begin
         pop[grant] = 1'b1;
      end
   end

   // Next state and next output byte; outputs follow the state being entered
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      data_d  = IDL;
      valid_d = 1'b0;
      lane_d  = 2'd0;
      case (st_q)
         ST_RESET: begin
            st_d   = ST_INIT;
            cnt_d  = '0;
            data_d = COM;
         end
         ST_INIT: begin
            data_d = COM;
            cnt_d  = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (link_active && (cnt_q >= CNT_EXIT)) begin
               st_d   = ST_IDLE;
               data_d = IDL;
            end
         end
         ST_IDLE: begin
            if (!link_active) begin
               st_d   = ST_INIT;
               cnt_d  = '0;
               data_d = COM;
            end else if (~&fifo_empty) begin
               st_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (!link_active) begin
               st_d   = ST_INIT;
               cnt_d  = '0;
               data_d = COM;
            end else if (any_ready) begin
               data_d  = lane_data[grant];
               valid_d = 1'b1;
               lane_d  = grant;
               rr_d    = grant + 2'd1;
            end else begin
               st_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         st_q      <= ST_RESET;
         cnt_q     <= '0;
         rr_q      <= 2'd0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         lane_out  <= 2'd0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         data_out  <= data_d;
         valid_out <= valid_d;
         lane_out  <= lane_d;
      end
   end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: vector table for bring-up and arbitration,
// hand sequences for long link loss and mid-stream reset.
module tb_phy_tx_sched;

   logic       clk_4f = 1'b0;
   logic       reset;
   logic [3:0] fifo_empty;
   logic [7:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
   logic       link_active;
   logic [3:0] pop;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_out;
   logic [1:0] state;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       link;
      logic [3:0] empty;
      logic [3:0] exp_pop;
      logic [1:0] exp_state;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic [1:0] exp_lane;
   } vec_t;

   vec_t vecs[$];

   phy_tx_sched dut (
      .clk_4f      (clk_4f),
      .reset       (reset),
      .fifo_empty  (fifo_empty),
      .fifo_data0  (fifo_data0),
      .fifo_data1  (fifo_data1),
      .fifo_data2  (fifo_data2),
      .fifo_data3  (fifo_data3),
      .link_active (link_active),
      .pop         (pop),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .lane_out    (lane_out),
      .state       (state)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic add(input logic link, input logic [3:0] empty, input logic [3:0] p,
                      input logic [1:0] st, input logic [7:0] d, input logic v,
                      input logic [1:0] l);
      vec_t r;
      r.link = link; r.empty = empty; r.exp_pop = p; r.exp_state = st;
      r.exp_data = d; r.exp_valid = v; r.exp_lane = l;
      vecs.push_back(r);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] st, input logic [7:0] d,
                           input logic v, input logic [1:0] l);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".data"},  32'(data_out), 32'(d));
      chk({tag, ".valid"}, 32'(valid_out), 32'(v));
      chk({tag, ".lane"},  32'(lane_out), 32'(l));
   endtask

   initial begin
      int n;
      fifo_data0  = 8'h10;
      fifo_data1  = 8'h11;
      fifo_data2  = 8'h12;
      fifo_data3  = 8'h13;
      fifo_empty  = 4'hF;
      link_active = 1'b0;
      reset       = 1'b0;
      tick();
      tick();
      chk_outs("rst", 2'd0, 8'h00, 1'b0, 2'd0);
      chk("rst.pop", 32'(pop), 32'h0);

      // Link held low: stays in INIT sending COM, then IDLE one edge after lock
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_outs($sformatf("nolink%0d", i), 2'd1, 8'hBC, 1'b0, 2'd0);
      end
      link_active = 1'b1;
      tick();
      chk_outs("lock", 2'd2, 8'h7C, 1'b0, 2'd0);

      // Vector table from a fresh reset: link, empty, pop, state, data, valid, lane
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 2, 8'h7C, 0, 0);
      add(1, 4'hF, 4'h0, 2, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h0, 3, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h1, 3, 8'h10, 1, 0);
      add(1, 4'h0, 4'h2, 3, 8'h11, 1, 1);
      add(1, 4'h0, 4'h4, 3, 8'h12, 1, 2);
      add(1, 4'h0, 4'h8, 3, 8'h13, 1, 3);
      add(1, 4'h0, 4'h1, 3, 8'h10, 1, 0);
      add(1, 4'hD, 4'h2, 3, 8'h11, 1, 1);   // only lane 1: leaves rr=2
      add(1, 4'h5, 4'h8, 3, 8'h13, 1, 3);   // lanes 1,3 from rr=2
      add(1, 4'h5, 4'h2, 3, 8'h11, 1, 1);
      add(1, 4'h5, 4'h8, 3, 8'h13, 1, 3);
      add(1, 4'h5, 4'h2, 3, 8'h11, 1, 1);
      add(1, 4'hF, 4'h0, 2, 8'h7C, 0, 0);
      add(1, 4'hF, 4'h0, 2, 8'h7C, 0, 0);
      add(0, 4'h0, 4'h0, 1, 8'hBC, 0, 0);   // link drop with data arriving in IDLE
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'hF, 4'h0, 2, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h0, 3, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h4, 3, 8'h12, 1, 2);
      add(0, 4'h0, 4'h0, 1, 8'hBC, 0, 0);   // link drop during ACTIVE
      add(1, 4'h0, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'h0, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'h0, 4'h0, 1, 8'hBC, 0, 0);
      add(1, 4'h0, 4'h0, 2, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h0, 3, 8'h7C, 0, 0);
      add(1, 4'h0, 4'h8, 3, 8'h13, 1, 3);
      add(1, 4'h0, 4'h1, 3, 8'h10, 1, 0);

      fifo_empty  = 4'hF;
      link_active = 1'b1;
      do_reset();
      foreach (vecs[i]) begin
         link_active = vecs[i].link;
         fifo_empty  = vecs[i].empty;
         #1;
         chk($sformatf("v%0d.pop", i), 32'(pop), 32'(vecs[i].exp_pop));
         tick();
         chk_outs($sformatf("v%0d", i), vecs[i].exp_state, vecs[i].exp_data,
                  vecs[i].exp_valid, vecs[i].exp_lane);
      end

      // Reset mid-stream: pop and outputs clear without a clock edge
      #1;
      chk("pre_rst.pop", 32'(pop), 32'h2);
      reset = 1'b0;
      #1;
      chk("arst.pop", 32'(pop), 32'h0);
      chk_outs("arst", 2'd0, 8'h00, 1'b0, 2'd0);

      // Bring-up repeats: first valid byte on edge 7 after release, from lane 0
      tick();
      reset = 1'b1;
      n = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (valid_out === 1'b1) begin
            n = e;
            break;
         end
      end
      chk("first_valid_edge", 32'(n), 32'd7);
      chk_outs("first_valid", 2'd3, 8'h10, 1'b1, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
